change_dispenser: RTL and testbench
===================================

Name: change_dispenser

Overview:
- Payout controller that sits downstream of the vending FSM and consumes its vend and change outputs.
- Each accepted change request is queued in a small FIFO.
- Queued requests are converted into timed motor pulses on two coin hoppers: a 5-unit hopper and a 10-unit hopper.
- Each dispensed coin is confirmed by a coin sensor, with timeout, fault latching and a fallback of two 5s when the 10 hopper is empty.

Parameters:
- FIFO_DEPTH, 4: request queue entries; power of 2, minimum 2.
- PULSE_CYCLES, 3: cycles the hopper motor output is held high per coin.
- GAP_CYCLES, 2: idle cycles after each confirmed coin before the next action.
- TIMEOUT_CYCLES, 16: cycles allowed after the pulse ends for coin_sensed to arrive.

Ports:
- clk, input, 1: system clock; rising edge.
- rst, input, 1: asynchronous, active-low reset.
- vend, input, 1: request strobe from the vending FSM.
- change, input, 2: change code, sampled with vend. 00 = none, 01 = 5 units, 10 = 10 units, 11 = invalid.
- coin_sensed, input, 1: coin-drop sensor, active high, synchronous to clk.
- empty5, input, 1: 5-unit hopper is empty.
- empty10, input, 1: 10-unit hopper is empty.
- fault_clr, input, 1: clears the fault state.
- hop5, output, 1: 5-unit hopper motor drive.
- hop10, output, 1: 10-unit hopper motor drive.
- busy, output, 1: high when state is not IDLE or the FIFO is not empty.
- req_full, output, 1: FIFO full.
- dropped, output, 1: one-cycle pulse when a request is discarded.
- fault, output, 1: latched payout failure.

Behaviour:
- Reset (rst=0), asynchronous:
  - FIFO is emptied, FSM goes to IDLE, all counters are cleared.
  - hop5, hop10, busy, dropped and fault are 0; req_full is 0.
  - Reset mid-pulse drops the hopper outputs immediately.
- Push:
  - A request is pushed at a rising edge when vend=1 and change is 01 or 10.
  - Codes 00 and 11 are ignored and do not assert dropped.
  - If the FIFO is full and no pop occurs that cycle, the request is discarded and dropped=1 for one cycle.
  - A simultaneous push and pop while full is accepted.
- FSM states: IDLE, LOAD, PULSE, WAIT, GAP, FAULT.
- IDLE: moves to LOAD when the FIFO is not empty.
- LOAD: pops one entry and builds the payout plan.
  - Code 01: one 5-coin if !empty5; otherwise FAULT.
  - Code 10: one 10-coin if !empty10; else two 5-coins if !empty5; otherwise FAULT.
  - Then moves to PULSE.
- PULSE:
  - The selected hopper output is high for exactly PULSE_CYCLES cycles. Only one hopper output is ever high at a time.
  - A coin_sensed seen during PULSE is latched and counts as confirmation.
  - Then moves to WAIT.
- WAIT:
  - Goes to GAP on the confirmation latch or on coin_sensed.
  - Goes to FAULT if TIMEOUT_CYCLES cycles elapse with no confirmation.
- GAP: holds outputs low for GAP_CYCLES cycles.
  - If a second 5-coin remains, re-checks empty5: if set, goes to FAULT, otherwise back to PULSE.
  - Otherwise returns to IDLE.
- FAULT:
  - fault=1 and both hopper outputs are low.
  - The in-flight request is abandoned; FIFO contents are kept and pushes are still accepted.
  - fault_clr=1 moves to IDLE, with fault=0 from the next cycle.
- Latency: a request pushed into an idle, empty FIFO at edge E0 gives LOAD after E1 and the hop output high after E2.
- Extra coin_sensed pulses in IDLE or GAP are ignored.
- Counters saturate-free and are sized by $clog2 of their parameter.

Optional Feature:
- Macro: CHANGE_DISPENSER_TOTAL_EN.
- When defined:
  - Adds output paid_total [15:0], the count of confirmed coins in 5-unit steps: +1 per confirmed 5-coin, +2 per confirmed 10-coin.
  - It wraps at 65535 to 0 and resets to 0.
- When undefined: the port and the logic are absent, and all other behaviour is identical.

Test Plan:
- Single 5-unit request: rst released, vend=1 with change=01 for one cycle, empty5=0, coin_sensed pulsed 1 cycle after the pulse ends.
  - hop5 is high 3 cycles starting 2 cycles after the push.
  - GAP lasts 2 cycles, then IDLE; busy is 0 afterwards; fault stays 0.
- Fallback: change=10 with empty10=1 and empty5=0, sensor confirming each coin.
  - Two hop5 pulses of 3 cycles each, separated by at least 2 low cycles.
  - hop10 never goes high.
- Timeout: change=01 and no coin_sensed.
  - fault=1 exactly 16 cycles after hop5 falls; both hop outputs stay low.
  - fault_clr returns the block to IDLE and fault to 0.
- Overflow: with the FSM stalled in FAULT, push 5 requests of code 01.
  - req_full=1 after the 4th push; dropped pulses once on the 5th.
  - After fault_clr, exactly 4 payouts occur.
- Invalid codes: vend with change=11, and vend with change=00.
  - No push, dropped=0, busy stays 0.
- Reset mid-PULSE: assert rst during hop10 high.
  - hop10 is 0 in the same cycle; FIFO is empty and FSM is in IDLE after release.
  - With CHANGE_DISPENSER_TOTAL_EN defined, paid_total=0.

Source files
------------

// File: rtl/change_dispenser_if.sv
// change_dispenser_if: request/sensor/motor signal bundle for the change dispenser.
//   master : vending-side driver and hopper hardware model (drives vend, change, sensor, empties, fault_clr)
//   slave  : change_dispenser (drives hop5, hop10, busy, req_full, dropped, fault)
// With CHANGE_DISPENSER_TOTAL_EN defined, paid_total [15:0] is also carried (slave output).
interface change_dispenser_if;
  logic       vend;
  logic [1:0] change;
  logic       coin_sensed;
  logic       empty5;
  logic       empty10;
  logic       fault_clr;
  logic       hop5;
  logic       hop10;
  logic       busy;
  logic       req_full;
  logic       dropped;
  logic       fault;
`ifdef CHANGE_DISPENSER_TOTAL_EN
  logic [15:0] paid_total;

  modport master (
    output vend, change, coin_sensed, empty5, empty10, fault_clr,
    input  hop5, hop10, busy, req_full, dropped, fault, paid_total
  );
  modport slave (
    input  vend, change, coin_sensed, empty5, empty10, fault_clr,
    output hop5, hop10, busy, req_full, dropped, fault, paid_total
  );
`else
  modport master (
    output vend, change, coin_sensed, empty5, empty10, fault_clr,
    input  hop5, hop10, busy, req_full, dropped, fault
  );
  modport slave (
    input  vend, change, coin_sensed, empty5, empty10, fault_clr,
    output hop5, hop10, busy, req_full, dropped, fault
  );
`endif
endinterface

// File: rtl/change_dispenser.sv
// change_dispenser: queues change requests from the vending FSM and pays them out as timed
// motor pulses on a 5-unit and a 10-unit coin hopper, confirming each coin with a drop sensor.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : change_dispenser_if.slave
//          in : vend, change[1:0] (01=5, 10=10), coin_sensed, empty5, empty10, fault_clr
//          out: hop5, hop10, busy, req_full, dropped, fault
// Optional: define CHANGE_DISPENSER_TOTAL_EN to add bus.paid_total [15:0], a wrapping count of
// confirmed coins in 5-unit steps.
module change_dispenser #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned PULSE_CYCLES   = 3,
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst,
  change_dispenser_if.slave   bus
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {StIdle, StLoad, StPulse, StWait, StGap, StFault} state_e;

  state_e                state_q, state_d;
  // One bit per entry: 1 = 10-unit request, 0 = 5-unit request.
  logic [FIFO_DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [PW-1:0]         pcnt_q, pcnt_d;
  logic [GW-1:0]         gcnt_q, gcnt_d;
  logic [TW-1:0]         tcnt_q, tcnt_d;
  logic                  hop5_q, hop5_d, hop10_q, hop10_d;
  logic                  conf_q, conf_d;      // coin seen during the current pulse
  logic                  second_q, second_d;  // a second 5-coin is still owed (10 fallback)
  logic                  dropped_q, dropped_d;
  logic                  fault_q, fault_d;
`ifdef CHANGE_DISPENSER_TOTAL_EN
  logic                  is10_q, is10_d;
  logic [15:0]           total_q, total_d;
`endif

  logic push_req, pop, full, push_ok, head;

  always_comb begin
    push_req = bus.vend && ((bus.change == 2'b01) || (bus.change == 2'b10));
    pop      = (state_q == StLoad);
    full     = (cnt_q == CW'(FIFO_DEPTH));
    // A pop in the same cycle frees a slot, so a push into a full FIFO is still taken.
    push_ok  = push_req && (!full || pop);
    head     = mem_q[rd_ptr_q];

    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    state_d   = state_q;
    pcnt_d    = pcnt_q;
    gcnt_d    = gcnt_q;
    tcnt_d    = tcnt_q;
    hop5_d    = hop5_q;
    hop10_d   = hop10_q;
    conf_d    = conf_q;
    second_d  = second_q;
    fault_d   = fault_q;
    dropped_d = push_req && full && !pop;
`ifdef CHANGE_DISPENSER_TOTAL_EN
    is10_d    = is10_q;
    total_d   = total_q;
`endif

    if (push_ok) begin
      mem_d[wr_ptr_q] = (bus.change == 2'b10);
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push_ok && !pop) begin
      cnt_d = cnt_q + CW'(1);
    end else if (!push_ok && pop) begin
      cnt_d = cnt_q - CW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (cnt_q != '0) state_d = StLoad;
      end
      StLoad: begin
        pcnt_d   = '0;
        conf_d   = 1'b0;
        second_d = 1'b0;
        state_d  = StPulse;
        if (head && !bus.empty10) begin
          hop10_d = 1'b1;
`ifdef CHANGE_DISPENSER_TOTAL_EN
          is10_d  = 1'b1;
`endif
        end else if (!bus.empty5) begin
          hop5_d   = 1'b1;
          second_d = head;
`ifdef CHANGE_DISPENSER_TOTAL_EN
          is10_d   = 1'b0;
`endif
        end else begin
          fault_d = 1'b1;
          state_d = StFault;
        end
      end
      StPulse: begin
        if (bus.coin_sensed) conf_d = 1'b1;
        if (pcnt_q == PW'(PULSE_CYCLES - 1)) begin
          hop5_d  = 1'b0;
          hop10_d = 1'b0;
          tcnt_d  = '0;
          state_d = StWait;
        end else begin
          pcnt_d = pcnt_q + PW'(1);
        end
      end
      StWait: begin
        if (conf_q || bus.coin_sensed) begin
          gcnt_d  = '0;
          state_d = StGap;
`ifdef CHANGE_DISPENSER_TOTAL_EN
          total_d = total_q + (is10_q ? 16'd2 : 16'd1);
`endif
        end else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          fault_d = 1'b1;
          state_d = StFault;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      StGap: begin
        if (gcnt_q == GW'(GAP_CYCLES - 1)) begin
          if (!second_q) begin
            state_d = StIdle;
          end else if (bus.empty5) begin
            fault_d = 1'b1;
            state_d = StFault;
          end else begin
            hop5_d   = 1'b1;
            second_d = 1'b0;
            pcnt_d   = '0;
            conf_d   = 1'b0;
            state_d  = StPulse;
          end
        end else begin
          gcnt_d = gcnt_q + GW'(1);
        end
      end
      StFault: begin
        if (bus.fault_clr) begin
          fault_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      mem_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      pcnt_q    <= '0;
      gcnt_q    <= '0;
      tcnt_q    <= '0;
      hop5_q    <= 1'b0;
      hop10_q   <= 1'b0;
      conf_q    <= 1'b0;
      second_q  <= 1'b0;
      dropped_q <= 1'b0;
      fault_q   <= 1'b0;
`ifdef CHANGE_DISPENSER_TOTAL_EN
      is10_q    <= 1'b0;
      total_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      pcnt_q    <= pcnt_d;
      gcnt_q    <= gcnt_d;
      tcnt_q    <= tcnt_d;
      hop5_q    <= hop5_d;
      hop10_q   <= hop10_d;
      conf_q    <= conf_d;
      second_q  <= second_d;
      dropped_q <= dropped_d;
      fault_q   <= fault_d;
`ifdef CHANGE_DISPENSER_TOTAL_EN
      is10_q    <= is10_d;
      total_q   <= total_d;
`endif
    end
  end

  assign bus.hop5     = hop5_q;
  assign bus.hop10    = hop10_q;
  assign bus.busy     = (state_q != StIdle) || (cnt_q != '0);
  assign bus.req_full = full;
  assign bus.dropped  = dropped_q;
  assign bus.fault    = fault_q;
`ifdef CHANGE_DISPENSER_TOTAL_EN
  assign bus.paid_total = total_q;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
module tb_change_dispenser;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  // Hopper/sensor model state, written only by the negedge monitor.
  logic auto_sense = 1'b0;
  logic prev5 = 1'b0, prev10 = 1'b0;
  int   n5 = 0, n10 = 0, run5 = 0, low5 = 0, last_len5 = 0, last_gap5 = 0, both_hi = 0;

  change_dispenser_if bus ();

  change_dispenser dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Sensor answers one cycle after a motor pulse ends; also tallies pulses and their shape.
  always @(negedge clk) begin
    bus.coin_sensed = auto_sense && (prev5 || prev10) && !bus.hop5 && !bus.hop10;
    if (bus.hop5 && bus.hop10) both_hi++;
    if (bus.hop5) begin
      if (!prev5) begin
        n5++;
        last_gap5 = low5;
        run5 = 1;
      end else begin
        run5++;
      end
      low5 = 0;
    end else begin
      if (prev5) last_len5 = run5;
      low5++;
    end
    if (bus.hop10 && !prev10) n10++;
    prev5  = bus.hop5;
    prev10 = bus.hop10;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic get_sig(input int which);
    case (which)
      0:       return bus.hop5;
      1:       return bus.hop10;
      2:       return bus.busy;
      default: return bus.fault;
    endcase
  endfunction

  // Bounded wait for a signal to reach a value; expiry shows up as a failed comparison.
  task automatic wait_sig(input string tag, input int which, input logic val, input int budget,
                          output int cycles);
    cycles = 0;
    while (get_sig(which) !== val && cycles < budget) begin
      tick();
      cycles++;
    end
    check_eq(tag, 32'(get_sig(which)), 32'(val));
  endtask

  task automatic push(input logic [1:0] code);
    bus.vend   = 1'b1;
    bus.change = code;
    tick();
    bus.vend   = 1'b0;
    bus.change = 2'b00;
  endtask

  task automatic clear_fault();
    bus.fault_clr = 1'b1;
    tick();
    bus.fault_clr = 1'b0;
  endtask

  initial begin
    int cyc;
    int n5_0, n10_0;
    bus.vend      = 1'b0;
    bus.change    = 2'b00;
    bus.empty5    = 1'b0;
    bus.empty10   = 1'b0;
    bus.fault_clr = 1'b0;

    // Reset state
    tick();
    tick();
    check_eq("rst_hop5", 32'(bus.hop5), 0);
    check_eq("rst_hop10", 32'(bus.hop10), 0);
    check_eq("rst_busy", 32'(bus.busy), 0);
    check_eq("rst_full", 32'(bus.req_full), 0);
    check_eq("rst_dropped", 32'(bus.dropped), 0);
    check_eq("rst_fault", 32'(bus.fault), 0);
    rst = 1'b1;
    tick();

    // Single 5-unit request: hop5 high for edges E2..E4, GAP after E6/E7, idle after E8
    auto_sense = 1'b1;
    n5_0 = n5;
    push(2'b01);
    check_eq("s5_busy_e0", 32'(bus.busy), 1);
    tick();
    check_eq("s5_hop5_e1", 32'(bus.hop5), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("s5_hop5_hi", 32'(bus.hop5), 1);
    end
    tick();
    check_eq("s5_hop5_e5", 32'(bus.hop5), 0);
    tick();
    tick();
    check_eq("s5_busy_gap", 32'(bus.busy), 1);
    tick();
    check_eq("s5_busy_idle", 32'(bus.busy), 0);
    check_eq("s5_fault", 32'(bus.fault), 0);
    check_eq("s5_npulse", 32'(n5 - n5_0), 1);
    check_eq("s5_len", 32'(last_len5), 3);

    // Fallback: 10 request with 10-hopper empty -> two 5-coins
    bus.empty10 = 1'b1;
    n5_0  = n5;
    n10_0 = n10;
    push(2'b10);
    wait_sig("fb_done", 2, 1'b0, 100, cyc);
    check_eq("fb_n5", 32'(n5 - n5_0), 2);
    check_eq("fb_n10", 32'(n10 - n10_0), 0);
    check_eq("fb_len", 32'(last_len5), 3);
    check_eq("fb_gap_ge2", 32'(last_gap5 >= 2), 1);
    check_eq("fb_fault", 32'(bus.fault), 0);
    bus.empty10 = 1'b0;

    // Timeout: no sensor, fault 16 cycles after hop5 falls
    auto_sense = 1'b0;
    push(2'b01);
    wait_sig("to_hop5_rise", 0, 1'b1, 20, cyc);
    wait_sig("to_hop5_fall", 0, 1'b0, 20, cyc);
    wait_sig("to_fault_rise", 3, 1'b1, 40, cyc);
    check_eq("to_fault_delay", 32'(cyc), 16);
    check_eq("to_hop5_low", 32'(bus.hop5), 0);
    check_eq("to_hop10_low", 32'(bus.hop10), 0);
    clear_fault();
    check_eq("to_fault_clr", 32'(bus.fault), 0);
    check_eq("to_busy_clr", 32'(bus.busy), 0);

    // Overflow: stall in FAULT via empty 5-hopper, then overfill the queue
    bus.empty5 = 1'b1;
    push(2'b01);
    wait_sig("ov_fault", 3, 1'b1, 10, cyc);
    bus.vend   = 1'b1;
    bus.change = 2'b01;
    for (int i = 0; i < 4; i++) tick();
    check_eq("ov_full4", 32'(bus.req_full), 1);
    check_eq("ov_nodrop4", 32'(bus.dropped), 0);
    tick();
    check_eq("ov_drop5", 32'(bus.dropped), 1);
    bus.vend   = 1'b0;
    bus.change = 2'b00;
    tick();
    check_eq("ov_drop_pulse", 32'(bus.dropped), 0);
    bus.empty5 = 1'b0;
    auto_sense = 1'b1;
    n5_0 = n5;
    clear_fault();
    wait_sig("ov_drain", 2, 1'b0, 300, cyc);
    check_eq("ov_payouts", 32'(n5 - n5_0), 4);
    check_eq("ov_fault", 32'(bus.fault), 0);
    check_eq("ov_full_end", 32'(bus.req_full), 0);

    // Invalid codes: no push, no drop
    push(2'b11);
    check_eq("inv11_busy", 32'(bus.busy), 0);
    check_eq("inv11_drop", 32'(bus.dropped), 0);
    push(2'b00);
    check_eq("inv00_busy", 32'(bus.busy), 0);
    check_eq("inv00_drop", 32'(bus.dropped), 0);
    tick();
    check_eq("inv_busy_late", 32'(bus.busy), 0);

`ifdef CHANGE_DISPENSER_TOTAL_EN
    check_eq("total_paid", 32'(bus.paid_total), 7);
`endif

    // Reset mid-pulse on the 10 hopper
    auto_sense = 1'b0;
    push(2'b10);
    wait_sig("rs_hop10_rise", 1, 1'b1, 20, cyc);
    rst = 1'b0;
    #1;
    check_eq("rs_hop10_async", 32'(bus.hop10), 0);
    tick();
    rst = 1'b1;
    tick();
    check_eq("rs_busy", 32'(bus.busy), 0);
    check_eq("rs_hop10", 32'(bus.hop10), 0);
    check_eq("rs_fault", 32'(bus.fault), 0);
`ifdef CHANGE_DISPENSER_TOTAL_EN
    check_eq("rs_total", 32'(bus.paid_total), 0);
`endif
    tick();
    check_eq("rs_idle_hop5", 32'(bus.hop5), 0);
    check_eq("both_hop_never", 32'(both_hi), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
